// File: rtl/cpu_control_pkg.sv
// cpu_control_pkg: shared opcode, ALU op and FSM state encodings for the controller and its ALU.
package cpu_control_pkg;
  localparam logic [6:0] OPC_LUI = 7'b0110111;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP = 7'b0110011;
  localparam logic [31:0] ECALL = 32'h0000_0073;
  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_OR = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;
  function automatic logic [3:0] f3_decode(input logic [2:0] f3);
    return f3 == 3'b000 ? {1'b1, ALU_ADD} :
           f3 == 3'b100 ? {1'b1, ALU_XOR} :
           f3 == 3'b110 ? {1'b1, ALU_OR} :
           f3 == 3'b111 ? {1'b1, ALU_AND} : {1'b0, ALU_PASS};
  endfunction
endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: classifies an instruction of the supported RISC-V subset and extracts ALU controls.
module instr_decoder
  import cpu_control_pkg::*;
(
  input  logic [31:0] instr,
  output logic        is_valid,
  output logic        is_ecall,
  output logic [2:0]  alu_op,
  output logic        use_imm,
  output logic        is_lui,
  output logic [31:0] imm,
  output logic [4:0]  rd
);
  logic       f3_ok;
  logic [2:0] f3_op;
  always_comb begin
    {f3_ok, f3_op} = f3_decode(instr[14:12]);
    is_lui = instr[6:0] == OPC_LUI;
    use_imm = instr[6:0] == OPC_OPIMM;
    is_ecall = instr == ECALL;
    is_valid = is_lui || (use_imm && f3_ok) || (instr[6:0] == OPC_OP && instr[31:25] == 7'b0 && f3_ok);
    alu_op = is_lui ? ALU_PASS : f3_op;
    imm = is_lui ? {instr[31:12], 12'b0} : {{20{instr[31]}}, instr[31:20]};
    rd = instr[11:7];
  end
endmodule

// File: rtl/cpu_control.sv
// cpu_control: multi-cycle fetch/decode/execute/writeback controller owning the PC.
module cpu_control
  import cpu_control_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [4:0]      rf_ra1,
  output logic [4:0]      rf_ra2,
  input  logic [XLEN-1:0] rf_rd1,
  input  logic [XLEN-1:0] rf_rd2,
  output logic [XLEN-1:0] alu_src_a,
  output logic [XLEN-1:0] alu_src_b,
  output logic [2:0]      alu_op,
  input  logic [XLEN-1:0] alu_res,
  output logic            rf_we,
  output logic [4:0]      rf_wa,
  output logic [XLEN-1:0] rf_wd,
  output logic            halted,
  output logic            illegal
);
  state_t          state;
  logic [XLEN-1:0] pc, instr, d_imm;
  logic            d_valid, d_is_ecall, d_use_imm, d_is_lui;
  logic [2:0]      d_alu_op;
  logic [4:0]      d_rd;
  instr_decoder u_dec (
    .instr(instr), .is_valid(d_valid), .is_ecall(d_is_ecall), .alu_op(d_alu_op),
    .use_imm(d_use_imm), .is_lui(d_is_lui), .imm(d_imm), .rd(d_rd)
  );
  // Outputs are registered one state ahead so they are stable for the whole owning state;
  // rf_wd doubles as the latched ALU result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      pc <= RESET_PC;
      instr <= '0;
      imem_req <= 1'b0;
      imem_addr <= RESET_PC;
      rf_ra1 <= '0;
      rf_ra2 <= '0;
      alu_src_a <= '0;
      alu_src_b <= '0;
      alu_op <= ALU_PASS;
      rf_we <= 1'b0;
      rf_wa <= '0;
      rf_wd <= '0;
      halted <= 1'b0;
      illegal <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_FETCH;
          imem_req <= 1'b1;
          imem_addr <= pc;
        end
        S_FETCH: if (imem_valid) begin
          state <= S_DECODE;
          instr <= imem_rdata;
          rf_ra1 <= imem_rdata[19:15];
          rf_ra2 <= imem_rdata[24:20];
          imem_req <= 1'b0;
        end
        S_DECODE: if (d_valid) begin
          state <= S_EXEC;
          alu_src_a <= d_is_lui ? d_imm : rf_rd1;
          alu_src_b <= d_is_lui ? '0 : d_use_imm ? d_imm : rf_rd2;
          alu_op <= d_alu_op;
        end else begin
          state <= S_HALT;
          halted <= 1'b1;
          illegal <= !d_is_ecall;
        end
        S_EXEC: begin
          state <= S_WB;
          rf_we <= |d_rd;
          rf_wa <= d_rd;
          rf_wd <= alu_res;
        end
        S_WB: begin
          state <= S_FETCH;
          rf_we <= 1'b0;
          pc <= pc + XLEN'(4);
          imem_addr <= pc + XLEN'(4);
          imem_req <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_control.sv
// tb_cpu_control: random and directed instruction streams checked against an architectural model.
module tb_cpu_control;
  logic        clk = 0, rst = 1, imem_valid = 0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req, rf_we, halted, illegal;
  logic [31:0] imem_addr, rf_rd1, rf_rd2, alu_src_a, alu_src_b, alu_res, rf_wd;
  logic [4:0]  rf_ra1, rf_ra2, rf_wa;
  logic [2:0]  alu_op;
  logic        w_imem_req, w_rf_we, w_halted, w_illegal;
  logic [31:0] w_imem_addr, w_alu_src_a, w_alu_src_b, w_rf_wd;
  logic [4:0]  w_rf_ra1, w_rf_ra2, w_rf_wa;
  logic [2:0]  w_alu_op;
  logic [31:0] regs [32];
  logic [31:0] pc_m, pc_w;
  logic [2:0]  f3s [4] = '{3'd0, 3'd4, 3'd6, 3'd7};
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  assign rf_rd1 = regs[rf_ra1];
  assign rf_rd2 = regs[rf_ra2];
  assign alu_res = alu_op == 3'b000 ? alu_src_a : alu_op == 3'b001 ? alu_src_a + alu_src_b :
                   alu_op == 3'b100 ? alu_src_a ^ alu_src_b : alu_op == 3'b110 ? alu_src_a | alu_src_b :
                   alu_op == 3'b111 ? alu_src_a & alu_src_b : 32'hDEAD_BEEF;

  cpu_control dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid),
    .imem_rdata(imem_rdata), .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .alu_res(alu_res),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .halted(halted), .illegal(illegal)
  );

  cpu_control #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst), .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_valid(imem_valid),
    .imem_rdata(imem_rdata), .rf_ra1(w_rf_ra1), .rf_ra2(w_rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .alu_src_a(w_alu_src_a), .alu_src_b(w_alu_src_b), .alu_op(w_alu_op), .alu_res(alu_res),
    .rf_we(w_rf_we), .rf_wa(w_rf_wa), .rf_wd(w_rf_wd), .halted(w_halted), .illegal(w_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // 0 = executes, 1 = ecall stop, 2 = illegal stop
  function automatic int classify(input logic [31:0] i);
    logic f3ok;
    f3ok = i[14:12] inside {3'd0, 3'd4, 3'd6, 3'd7};
    if (i == 32'h0000_0073) return 1;
    if (i[6:0] == 7'h37) return 0;
    if (i[6:0] == 7'h13) return f3ok ? 0 : 2;
    if (i[6:0] == 7'h33) return (f3ok && i[31:25] == 7'd0) ? 0 : 2;
    return 2;
  endfunction

  function automatic logic [31:0] apply(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return a + b;
      3'd4: return a ^ b;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic do_reset;
    rst = 1;
    imem_valid = 0;
    step();
    step();
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_addr_w", w_imem_addr, 32'hFFFF_FFFC);
    chk("rst_state_outs", {halted, illegal, rf_we, alu_op, rf_ra1, rf_ra2, rf_wa}, 0);
    chk("rst_src_a", alu_src_a, 0);
    chk("rst_wd", rf_wd, 0);
    rst = 0;
    step();
    pc_m = 32'h0;
    pc_w = 32'hFFFF_FFFC;
  endtask

  task automatic run_instr(input logic [31:0] ins, input int wt);
    int cls;
    logic lui;
    logic [31:0] a, b, r;
    logic [2:0] op;
    cls = classify(ins);
    lui = ins[6:0] == 7'h37;
    a = lui ? {ins[31:12], 12'h0} : regs[ins[19:15]];
    b = lui ? 32'h0 : (ins[6:0] == 7'h13) ? {{20{ins[31]}}, ins[31:20]} : regs[ins[24:20]];
    op = lui ? 3'b000 : (ins[14:12] == 3'd0) ? 3'b001 : ins[14:12];
    r = lui ? a : apply(ins[14:12], a, b);
    chk("fetch_req", imem_req, 1);
    chk("fetch_req_w", w_imem_req, 1);
    chk("fetch_addr", imem_addr, pc_m);
    chk("fetch_addr_w", w_imem_addr, pc_w);
    for (int k = 0; k < wt; k++) begin
      step();
      chk("wait_req", imem_req, 1);
      chk("wait_addr", imem_addr, pc_m);
      chk("wait_we", rf_we, 0);
    end
    imem_valid = 1;
    imem_rdata = ins;
    step();
    imem_valid = 0;
    imem_rdata = $urandom;
    chk("dec_req", imem_req, 0);
    chk("dec_ra1", rf_ra1, ins[19:15]);
    chk("dec_ra2", rf_ra2, ins[24:20]);
    chk("dec_ra1_w", w_rf_ra1, ins[19:15]);
    chk("dec_ra2_w", w_rf_ra2, ins[24:20]);
    if (cls != 0) begin
      step();
      chk("halt", halted, 1);
      chk("halt_illegal", illegal, cls == 2);
      chk("halt_w", {w_halted, w_illegal}, {1'b1, cls == 2});
      imem_valid = 1;
      for (int k = 0; k < 22; k++) begin
        step();
        chk("halt_quiet", {halted, illegal, imem_req, rf_we}, {1'b1, cls == 2, 2'b00});
      end
      imem_valid = 0;
      return;
    end
    step();
    chk("exec_op", alu_op, op);
    chk("exec_a", alu_src_a, a);
    chk("exec_b", alu_src_b, b);
    chk("exec_we", rf_we, 0);
    chk("exec_w", {w_alu_op, w_alu_src_a, w_alu_src_b}, {op, a, b});
    step();
    chk("wb_we", rf_we, ins[11:7] != 5'd0);
    chk("wb_wa", rf_wa, ins[11:7]);
    chk("wb_wd", rf_wd, r);
    chk("wb_w", {w_rf_we, w_rf_wa, w_rf_wd}, {ins[11:7] != 5'd0, ins[11:7], r});
    if (ins[11:7] != 5'd0) regs[ins[11:7]] = r;
    step();
    pc_m += 4;
    pc_w += 4;
    chk("next_we", rf_we, 0);
  endtask

  initial begin
    logic [31:0] u, ins;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    for (int i = 0; i < 32; i++) regs[i] = '0;
    do_reset();
    run_instr(32'h0050_0093, 0);
    chk("addi_x1", regs[1], 32'd5);
    run_instr(32'h1234_5137, 0);
    regs[1] = 32'h0F0F_0F0F;
    regs[2] = 32'h00FF_00FF;
    run_instr(32'h0020_C1B3, 0);
    chk("xor_x3", regs[3], 32'h0FF0_0FF0);
    run_instr(32'h0010_0013, 3);
    for (int i = 1; i < 32; i++) regs[i] = $urandom;
    for (int n = 0; n < 40; n++) begin
      u = $urandom;
      rd = 5'($urandom);
      rs1 = 5'($urandom);
      rs2 = 5'($urandom);
      f3 = f3s[$urandom_range(0, 3)];
      case ($urandom_range(0, 2))
        0: ins = {u[31:12], rd, 7'h37};
        1: ins = {u[31:20], rs1, f3, rd, 7'h13};
        default: ins = {7'd0, rs2, rs1, f3, rd, 7'h33};
      endcase
      run_instr(ins, $urandom_range(0, 2));
    end
    imem_valid = 1;
    imem_rdata = 32'h0070_0293;
    step();
    imem_valid = 0;
    step();
    rst = 1;
    #1;
    chk("mid_rst_req", imem_req, 0);
    chk("mid_rst_addr", imem_addr, 32'h0);
    chk("mid_rst_alu", {alu_op, alu_src_a, alu_src_b}, 0);
    chk("mid_rst_wb", {rf_we, rf_wa, rf_wd}, 0);
    step();
    chk("mid_rst_no_we", rf_we, 0);
    do_reset();
    run_instr(32'h0000_0073, 0);
    do_reset();
    run_instr(32'hFFFF_FFFF, 1);
    do_reset();
    run_instr(32'h0000_1013, 0);
    do_reset();
    run_instr(32'h4000_0033, 0);
    do_reset();
    run_instr(32'h0030_0213, 0);
    chk("post_halt_x4", regs[4], 32'd3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
